hdmi_fb_fetch: RTL and testbench

- Framebuffer fetch engine directly upstream of the HDMI pixel FIFO, in the clk_i domain.
- On each frame start it reads the packed 24-bit framebuffer from memory over a pipelined Wishbone master.
- It unpacks the 32-bit words into 24-bit pixels and pushes them into the write side of the async pixel FIFO.
- The HDMI core drains that FIFO in the pixel clock domain.

---
 rtl/hdmi_fb_fetch.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_fb_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_fb_fetch.sv
// Framebuffer fetch engine: reads packed 24-bit pixels over pipelined Wishbone
// and unpacks 32-bit words into the write side of the HDMI pixel FIFO.
module hdmi_fb_fetch #(
    parameter int H_PIXELS        = 640,
    parameter int V_LINES         = 480,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        enable_i,
    input  logic        frame_start_i,
    input  logic [31:0] base_addr_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_addr_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    input  logic        wb_err_i,
    output logic        fifo_wr_o,
    output logic [23:0] fifo_wdata_o,
    input  logic        fifo_full_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o
);
    localparam int NPIX   = H_PIXELS * V_LINES;
    localparam int NWORDS = NPIX * 3 / 4;
    localparam int RW     = ($clog2(NWORDS) > 18) ? $clog2(NWORDS) : 18;
    localparam int PXW    = ($clog2(NPIX) > 19) ? $clog2(NPIX) : 19;
    localparam int CW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [RW-1:0]   req_cnt_q, req_cnt_d;
    logic [PXW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]   outst_q, outst_d, buf_cnt_q, buf_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]     buf_q [MAX_OUTSTANDING];
    logic [31:0]     buf_d [MAX_OUTSTANDING];
    logic [47:0]     acc_q, acc_d, acc_mid;
    logic [2:0]      r_q, r_d, r_mid;
    logic            fifo_wr_q, fifo_wr_d, frame_done_q, frame_done_d, err_q, err_d;
    logic [23:0]     fifo_wdata_q, fifo_wdata_d;
    logic            busy, stb, start, abort, accept, ack, emit, absorb, last_req;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (abort) state_d = IDLE;
                     else if (accept && last_req) state_d = DRAIN;
            DRAIN:   if (abort || frame_done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Budget counts words in flight plus words already buffered, so an ack can
    // always be stored and the buffer never overflows.
    always_comb begin
        busy     = (state_q != IDLE);
        stb      = (state_q == FETCH) &&
                   (({1'b0, outst_q} + {1'b0, buf_cnt_q}) < (CW+1)'(MAX_OUTSTANDING));
        start    = (state_q == IDLE) && frame_start_i && enable_i;
        abort    = busy && (wb_err_i || !enable_i);
        accept   = stb && !wb_stall_i;
        ack      = busy && wb_ack_i && (outst_q != '0);
        emit     = busy && !abort && (r_q >= 3'd3) && !fifo_full_i;
        last_req = (req_cnt_q == RW'(NWORDS - 1));
        wb_stb_o = stb;
        wb_cyc_o = stb || (outst_q != '0);
        busy_o   = busy;
    end

    always_comb begin
        addr_d       = addr_q;
        req_cnt_d    = req_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        outst_d      = outst_q;
        buf_cnt_d    = buf_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        buf_d        = buf_q;
        acc_d        = acc_q;
        r_d          = r_q;
        err_d        = err_q;
        fifo_wr_d    = 1'b0;
        frame_done_d = 1'b0;
        fifo_wdata_d = fifo_wdata_q;
        r_mid        = r_q;
        acc_mid      = acc_q;
        absorb       = 1'b0;
        if (start) begin
            addr_d    = base_addr_i;
            req_cnt_d = '0;
            pix_cnt_d = '0;
            err_d     = 1'b0;
            outst_d   = '0;
            buf_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            acc_d     = '0;
            r_d       = '0;
        end else if (abort) begin
            if (wb_err_i) err_d = 1'b1;
            outst_d   = '0;
            buf_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            acc_d     = '0;
            r_d       = '0;
        end else if (busy) begin
            if (accept) begin
                addr_d    = addr_q + 32'd4;
                req_cnt_d = req_cnt_q + 1'b1;
            end
            if (ack) begin
                buf_d[wr_ptr_q] = wb_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (emit) begin
                fifo_wr_d    = 1'b1;
                fifo_wdata_d = acc_q[23:0];
                frame_done_d = (pix_cnt_q == PXW'(NPIX - 1));
                pix_cnt_d    = pix_cnt_q + 1'b1;
                r_mid        = r_q - 3'd3;
                acc_mid      = acc_q >> 24;
            end
            // Absorb after the emit shift so both can happen in one cycle.
            absorb = (buf_cnt_q != '0) && (r_mid <= 3'd2);
            acc_d  = acc_mid;
            r_d    = r_mid;
            if (absorb) begin
                acc_d    = acc_mid | ({16'h0, buf_q[rd_ptr_q]} << {r_mid, 3'b000});
                r_d      = r_mid + 3'd4;
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            outst_d   = outst_q + CW'(accept) - CW'(ack);
            buf_cnt_d = buf_cnt_q + CW'(ack) - CW'(absorb);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q       <= '0;
            req_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            outst_q      <= '0;
            buf_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) buf_q[i] <= '0;
            acc_q        <= '0;
            r_q          <= '0;
            err_q        <= 1'b0;
            fifo_wr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            addr_q       <= addr_d;
            req_cnt_q    <= req_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            outst_q      <= outst_d;
            buf_cnt_q    <= buf_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            buf_q        <= buf_d;
            acc_q        <= acc_d;
            r_q          <= r_d;
            err_q        <= err_d;
            fifo_wr_q    <= fifo_wr_d;
            frame_done_q <= frame_done_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

    assign wb_we_o      = 1'b0;
    assign wb_sel_o     = 4'hF;
    assign wb_addr_o    = addr_q;
    assign fifo_wr_o    = fifo_wr_q;
    assign fifo_wdata_o = fifo_wdata_q;
    assign frame_done_o = frame_done_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_hdmi_fb_fetch.sv
// Scoreboard bench: random Wishbone slave with stalls/latency, pixel stream
// compared against bytes computed straight from the memory layout.
module tb_hdmi_fb_fetch;
  localparam int HP = 8, VL = 2, NPIX = HP * VL, NWORDS = NPIX * 3 / 4, MAXO = 4;

  logic clk = 0, rstn = 1, enable = 0, frame_start = 0, fifo_full = 0;
  logic [31:0] base_addr = 0, wb_data = 0;
  logic wb_ack = 0, wb_stall = 0, wb_err = 0;
  logic wb_cyc_o, wb_stb_o, wb_we_o, fifo_wr_o, busy_o, frame_done_o, err_o;
  logic [31:0] wb_addr_o;
  logic [3:0] wb_sel_o;
  logic [23:0] fifo_wdata_o;

  hdmi_fb_fetch #(.H_PIXELS(HP), .V_LINES(VL), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .frame_start_i(frame_start),
    .base_addr_i(base_addr), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o), .wb_data_i(wb_data), .wb_ack_i(wb_ack),
    .wb_stall_i(wb_stall), .wb_err_i(wb_err), .fifo_wr_o(fifo_wr_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_full_i(fifo_full), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_o(err_o));

  always #5 clk = ~clk;

  typedef struct { logic [23:0] pix; logic last; } exp_t;
  typedef struct { int due; logic [31:0] a; } pend_t;
  exp_t  exp_q[$];
  pend_t pend[$];

  int checks = 0, failures = 0;
  int salt = 0, stall_pct = 0, max_lat = 1, err_on_ack = 0;
  int req_cnt = 0, wr_pix = 0, ack_num = 0, cyc_n = 0;
  logic [31:0] exp_addr = 0, hold_addr = 0;
  logic hold_chk = 0, err_chk = 0, done_chk = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [7:0] s;
    s = salt[7:0];
    if (salt == 0) return a[7:0];
    return a[7:0] ^ a[15:8] ^ s;
  endfunction

  // Wishbone slave: decisions made on the falling edge, seen by the DUT on the next rise.
  always @(negedge clk) begin : slave
    pend_t p;
    cyc_n++;
    if (err_chk) begin
      err_chk = 0;
      check("cyc_after_err", wb_cyc_o, 0);
      check("err_flag", err_o, 1);
      check("busy_after_err", busy_o, 0);
    end
    if (hold_chk && busy_o) begin
      check("stall_hold_stb", wb_stb_o, 1);
      check("stall_hold_addr", wb_addr_o, hold_addr);
    end
    hold_chk = 0;
    if (!wb_cyc_o) pend.delete();
    wb_ack = 0; wb_err = 0; wb_data = 0;
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      p = pend.pop_front();
      ack_num++;
      if (ack_num == err_on_ack) begin
        wb_err = 1; exp_q.delete(); err_chk = 1;
      end else begin
        wb_ack = 1;
        wb_data = {mb(p.a + 3), mb(p.a + 2), mb(p.a + 1), mb(p.a)};
      end
    end
    wb_stall = ($urandom_range(99) < stall_pct);
    if (wb_cyc_o && wb_stb_o && !wb_err) begin
      if (wb_stall) begin
        hold_chk = 1; hold_addr = wb_addr_o;
      end else begin
        check("req_addr", wb_addr_o, exp_addr);
        exp_addr += 4;
        req_cnt++;
        p.due = cyc_n + $urandom_range(max_lat, 1);
        p.a = wb_addr_o;
        pend.push_back(p);
        if (pend.size() > MAXO) check("outstanding_budget", pend.size(), MAXO);
      end
    end
  end

  // Monitor: pops the scoreboard on every pixel write.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (done_chk) begin
      done_chk = 0;
      check("busy_after_done", busy_o, 0);
    end
    if (fifo_wr_o) begin
      wr_pix++;
      check("no_wr_while_full", fifo_full, 0);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL extra_write: got %06h expected no write at %0t", fifo_wdata_o, $time);
      end else begin
        e = exp_q.pop_front();
        check("pixel", fifo_wdata_o, e.pix);
        check("frame_done", frame_done_o, e.last);
        if (e.last) begin
          check("busy_at_done", busy_o, 1);
          done_chk = 1;
        end
      end
    end else if (frame_done_o) begin
      check("done_without_write", fifo_wr_o, 1);
    end
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic start_frame(input logic [31:0] b, input int s, input bit push);
    exp_t e;
    logic [31:0] a;
    salt = s; exp_addr = b; req_cnt = 0; wr_pix = 0; ack_num = 0;
    if (push)
      for (int n = 0; n < NPIX; n++) begin
        a = b + 32'(3 * n);
        e.pix = {mb(a + 2), mb(a + 1), mb(a)};
        e.last = (n == NPIX - 1);
        exp_q.push_back(e);
      end
    base_addr = b; frame_start = 1;
    step();
    frame_start = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin step(); n++; end
    check(name, busy_o, 0);
  endtask

  task automatic frame_end_checks();
    step(); step();
    check("frame_reqs", req_cnt, NWORDS);
    check("frame_pixels", wr_pix, NPIX);
    check("sb_empty", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_base();
    return 32'h0010_0000 | ($urandom & 32'h0000_FFFC);
  endfunction

  initial begin
    int n, held;
    #1 rstn = 0;
    #1;
    check("rst_cyc", wb_cyc_o, 0); check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);   check("rst_addr", wb_addr_o, 0);
    check("rst_wr", fifo_wr_o, 0); check("rst_wdata", fifo_wdata_o, 0);
    check("rst_busy", busy_o, 0);  check("rst_done", frame_done_o, 0);
    check("rst_err", err_o, 0);
    step(); step(); rstn = 1; enable = 1; step();

    start_frame(32'h1000, 0, 1);
    wait_idle("nominal_timeout", 300);
    frame_end_checks();

    stall_pct = 50; max_lat = 5;
    for (int i = 0; i < 4; i++) begin
      start_frame(rand_base(), $urandom_range(255, 1), 1);
      wait_idle("random_timeout", 2000);
      frame_end_checks();
    end

    stall_pct = 0; max_lat = 3;
    start_frame(rand_base(), $urandom_range(255, 1), 1);
    n = 0;
    while (wr_pix < 4 && n < 200) begin step(); n++; end
    fifo_full = 1;
    repeat (100) step();
    held = 4 * req_cnt - 3 * wr_pix;
    checks++;
    if (held < 19 || held > 22) begin
      failures++;
      $display("FAIL full_budget: bytes held %0d expected 19..22", held);
    end
    check("full_no_stb", wb_stb_o, 0);
    fifo_full = 0;
    wait_idle("full_timeout", 500);
    frame_end_checks();

    stall_pct = 25; max_lat = 2; err_on_ack = 6;
    start_frame(rand_base(), $urandom_range(255, 1), 1);
    wait_idle("err_timeout", 500);
    step(); step();
    check("err_sticky", err_o, 1);
    check("err_sb_flushed", exp_q.size(), 0);
    err_on_ack = 0;
    start_frame(rand_base(), $urandom_range(255, 1), 1);
    check("err_cleared", err_o, 0);
    wait_idle("post_err_timeout", 1000);
    frame_end_checks();
    check("err_still_clear", err_o, 0);

    start_frame(32'h0000_2000, $urandom_range(255, 1), 1);
    repeat (5) step();
    base_addr = 32'h0000_8000; frame_start = 1;
    step();
    frame_start = 0;
    wait_idle("ignored_start_timeout", 1000);
    frame_end_checks();

    start_frame(rand_base(), $urandom_range(255, 1), 1);
    repeat (6) step();
    enable = 0; exp_q.delete();
    step(); step();
    check("dis_busy", busy_o, 0); check("dis_err", err_o, 0); check("dis_cyc", wb_cyc_o, 0);
    step();

    base_addr = 32'h3000; frame_start = 1;
    step();
    frame_start = 0;
    step();
    check("start_disabled_busy", busy_o, 0);
    check("start_disabled_cyc", wb_cyc_o, 0);
    enable = 1;

    stall_pct = 50; max_lat = 4;
    start_frame(rand_base(), $urandom_range(255, 1), 1);
    repeat (8) step();
    rstn = 0;
    #1;
    check("arst_cyc", wb_cyc_o, 0); check("arst_stb", wb_stb_o, 0);
    check("arst_wr", fifo_wr_o, 0); check("arst_busy", busy_o, 0);
    check("arst_done", frame_done_o, 0); check("arst_err", err_o, 0);
    check("arst_addr", wb_addr_o, 0);
    exp_q.delete();
    step(); rstn = 1; step();
    start_frame(32'h0004_0000, $urandom_range(255, 1), 1);
    wait_idle("post_rst_timeout", 2000);
    frame_end_checks();

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
